serial_shift_port: RTL and testbench
====================================

Name:
serial_shift_port

Overview:
Memory-mapped serial shift port on the CPU bus. It decodes a parametrised base address and exposes two registers: DATA and CTRL/STATUS. Writing DATA launches a full-duplex, MSB-first serial transfer on sclk/sdo/sdi. This block generalises the earlier fixed-decode, fixed-width serial-read logic with a configurable address window, data width and clock divider, plus busy/done/overrun status and chip-select control.

Parameters:
ADDR_W, 14, width of bus address ba.
BASE, 14'h1000, base address of the register window; bits [3:0] must be 0.
DATA_W, 8, shift and bus data width; minimum 8.
DIV, 4, clk cycles per sclk half-period; minimum 1.
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
ba  in  ADDR_W  bus address.
br_w  in  1  bus direction: 1 = read, 0 = write.
sser_n  in  1  bus-cycle select, active low; the block responds only when low.
bus_stb  in  1  one-cycle access strobe; side effects occur only when it is high.
bd_in  in  DATA_W  write data.
bd_out  out  DATA_W  read data.
bd_oe  out  1  read-data drive enable.
sclk  out  1  serial clock; idles low (mode 0).
sdo  out  1  serial data out.
sdi  in  1  serial data in.
cs_n  out  1  device select, active low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - sclk=0, sdo=0, cs_n=1, bd_oe=0, bd_out=0.
  - tx/rx shift registers = 0.
  - busy=0, done=0, ovr=0, cs bit=0.
  - FSM in IDLE.
  - Asserting rst mid-transfer aborts at the next edge with no partial-data preservation.
- Address decode:
  - hit = ~sser_n & (ba[ADDR_W-1:4]==BASE[ADDR_W-1:4]) & (ba[3:1]==0).
  - ba[0]=0 selects DATA; ba[0]=1 selects CTRL.
- Read path:
  - Combinational. bd_oe = hit & br_w.
  - DATA read returns rx.
  - CTRL read returns {0..., cs, ovr, done, busy} in bits [3:0].
  - bd_out = 0 when bd_oe=0.
- Read side effect: a DATA read with bus_stb clears done at the edge.
- DATA write (hit & ~br_w & bus_stb & ba[0]=0):
  - When idle: tx<=bd_in, bit counter<=DATA_W, busy<=1, done<=0, FSM->LOW.
  - When busy: write ignored, ovr<=1.
- CTRL write:
  - bit3 -> cs, applied only when not busy; ignored while busy.
  - Writing 1 to bit2 clears ovr (write-1-clear).
  - Other bits ignored.
  - cs_n = ~cs, registered.
- FSM states IDLE, LOW, HIGH; a divider counter runs 0..DIV-1 in LOW and HIGH.
  - LOW: sclk=0, sdo=tx[DATA_W-1]. After DIV cycles -> HIGH; rx<={rx[DATA_W-2:0], sdi} is sampled on that transition edge.
  - HIGH: sclk=1. After DIV cycles, the bit counter decrements.
    - If the new count is 0: FSM->IDLE, busy<=0, done<=1, sclk<=0.
    - Otherwise: tx<<=1 and FSM->LOW.
  - IDLE: sclk=0; sdo holds its last value.
- Latency:
  - busy is visible on CTRL read the cycle after the DATA write strobe.
  - Transfer lasts exactly 2*DIV*DATA_W clk cycles.
  - done rises on the edge that ends the last HIGH phase.
- Simultaneous events:
  - The completion edge coinciding with a DATA read strobe leaves done=1 (set wins).
  - The completion edge coinciding with a DATA write strobe counts as busy: ovr<=1 and the write is ignored.
  - ovr set and W1C in the same cycle leaves ovr=1.
- Accesses with sser_n=1 or outside the window have no effect; bd_oe=0.

Test Plan:
Parameters for all scenarios: DIV=2, DATA_W=8, BASE=14'h1000.
- Reset: hold rst 2 cycles mid-transfer -> sclk=0, cs_n=1, CTRL reads 0x00, no further sclk edges.
- Basic transfer:
  - Setup: write CTRL=0x08, then DATA=0xA5, with sdi driven 0x3C MSB-first.
  - Expected during transfer: cs_n=0; 8 sclk pulses, each 2 cycles high / 2 low; sdo sequence 1,0,1,0,0,1,0,1.
  - Expected after completion: busy drops after exactly 32 cycles; CTRL=0x0A; DATA read=0x3C; CTRL then reads 0x08.
- Overrun:
  - Stimulus: write DATA=0x11, then write DATA=0x22 at cycle 5.
  - Expected: sdo carries 0x11; CTRL=0x0E at the end; write CTRL=0x0C -> CTRL=0x0A.
- Decode:
  - Stimulus: accesses at 0x1002, at 0x0000, and at 0x1000 with sser_n=1.
  - Expected: bd_oe=0 and no state change in all three cases.
- Completion collision:
  - Stimulus: DATA read strobe on the completion edge.
  - Expected: done remains 1; a DATA write on that edge sets ovr and tx is unchanged.
- CS lock: CTRL write 0x00 while busy -> cs_n stays 0 until an idle write.

Source files
------------

// File: rtl/serial_shift_port.sv
// Memory-mapped serial shift port: DATA and CTRL/STATUS registers in a small
// address window, with a full-duplex MSB-first mode-0 shifter behind them.
module serial_shift_port #(
  parameter int              ADDR_W = 14,
  parameter logic [ADDR_W-1:0] BASE = 14'h1000,
  parameter int              DATA_W = 8,
  parameter int              DIV    = 4,
  parameter int              CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ba,
  input  logic              br_w,
  input  logic              sser_n,
  input  logic              bus_stb,
  input  logic [DATA_W-1:0] bd_in,
  output logic [DATA_W-1:0] bd_out,
  output logic              bd_oe,
  output logic              sclk,
  output logic              sdo,
  input  logic              sdi,
  output logic              cs_n
);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx, rx;
  logic              busy, done, ovr, cs;

  logic hit, data_sel, ctrl_sel, wr_data, wr_ctrl, rd_data;
  logic phase_end, last_bit, fin;

  assign hit      = ~sser_n & (ba[ADDR_W-1:4] == BASE[ADDR_W-1:4]) & (ba[3:1] == 3'd0);
  assign data_sel = hit & ~ba[0];
  assign ctrl_sel = hit & ba[0];
  assign wr_data  = data_sel & ~br_w & bus_stb;
  assign wr_ctrl  = ctrl_sel & ~br_w & bus_stb;
  assign rd_data  = data_sel & br_w & bus_stb;

  assign phase_end = (div_cnt == DIV_W'(DIV - 1));
  assign last_bit  = (bit_cnt == CNT_W'(1));
  assign fin       = (state == HIGH) & phase_end & last_bit;

  // tx only shifts between bits, so its MSB is also the held idle value
  assign sdo = tx[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_data)   state_nx = LOW;
      LOW:     if (phase_end) state_nx = HIGH;
      HIGH:    if (phase_end) state_nx = last_bit ? IDLE : LOW;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sclk   = (state == HIGH);
    bd_oe  = hit & br_w;
    bd_out = '0;
    if (bd_oe) begin
      if (ba[0]) bd_out[3:0] = {cs, ovr, done, busy};
      else       bd_out      = rx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      cs      <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      if (state == IDLE || phase_end) div_cnt <= '0;
      else                            div_cnt <= div_cnt + 1'b1;

      if (state == IDLE && wr_data) begin
        tx      <= bd_in;
        bit_cnt <= CNT_W'(DATA_W);
        busy    <= 1'b1;
      end else if (state == HIGH && phase_end) begin
        bit_cnt <= bit_cnt - 1'b1;
        if (last_bit) busy <= 1'b0;
        else          tx   <= {tx[DATA_W-2:0], 1'b0};
      end

      if (state == LOW && phase_end) rx <= {rx[DATA_W-2:0], sdi};

      // completion set beats both clearing paths
      if (fin)                            done <= 1'b1;
      else if (state == IDLE && wr_data)  done <= 1'b0;
      else if (rd_data)                   done <= 1'b0;

      if (wr_data && busy)            ovr <= 1'b1;
      else if (wr_ctrl && bd_in[2])   ovr <= 1'b0;

      if (wr_ctrl && !busy) begin
        cs   <= bd_in[3];
        cs_n <= ~bd_in[3];
      end
    end
  end
endmodule

// File: tb/tb_serial_shift_port.sv
// Directed bench for serial_shift_port with DIV=2, DATA_W=8, BASE=0x1000.
module tb_serial_shift_port;
  localparam logic [13:0] A_DATA = 14'h1000;
  localparam logic [13:0] A_CTRL = 14'h1001;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] ba;
  logic        br_w, sser_n, bus_stb;
  logic [7:0]  bd_in, bd_out;
  logic        bd_oe, sclk, sdo, sdi, cs_n;

  int total = 0;
  int bad   = 0;
  int rises = 0, falls = 0, hi_cnt = 0;
  int r0, f0, h0, n;
  logic [7:0] sval = 8'h00;
  logic [7:0] sdo_cap = 8'h00;
  logic [7:0] q;
  logic       oe;

  serial_shift_port #(.ADDR_W(14), .BASE(14'h1000), .DATA_W(8), .DIV(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ba(ba), .br_w(br_w), .sser_n(sser_n), .bus_stb(bus_stb),
    .bd_in(bd_in), .bd_out(bd_out), .bd_oe(bd_oe), .sclk(sclk), .sdo(sdo), .sdi(sdi),
    .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // slave model: presents its byte MSB-first, advancing on each sclk fall
  assign sdi = sval[3'(7 - (falls - f0))];

  always @(posedge sclk) begin
    rises   = rises + 1;
    sdo_cap = {sdo_cap[6:0], sdo};
  end
  always @(negedge sclk) falls = falls + 1;
  always @(negedge clk) if (sclk) hi_cnt = hi_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic [13:0] a, input logic [7:0] d, input logic rw,
                     input logic sn, output logic [7:0] rq, output logic roe);
    @(negedge clk);
    ba = a; bd_in = d; br_w = rw; sser_n = sn; bus_stb = 1'b1;
    #1 rq = bd_out; roe = bd_oe;
    @(negedge clk);
    sser_n = 1'b1; bus_stb = 1'b0; br_w = 1'b1;
  endtask

  task automatic peek(input logic [13:0] a, output logic [7:0] rq, output logic roe);
    ba = a; br_w = 1'b1; sser_n = 1'b0; bus_stb = 1'b0;
    #1 rq = bd_out; roe = bd_oe;
    sser_n = 1'b1;
  endtask

  task automatic wait_idle(output int cyc);
    logic [7:0] s;
    logic       e;
    cyc = 0;
    while (cyc < 300) begin
      peek(A_CTRL, s, e);
      if (!s[0]) break;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 300) chk("idle_timeout", 32'(cyc), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ba = '0; br_w = 1'b1; sser_n = 1'b1; bus_stb = 1'b0; bd_in = '0;
    f0 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_oe", 32'(bd_oe), 32'd0);
    chk("rst_bd_out", 32'(bd_out), 32'd0);
    peek(A_CTRL, q, oe); chk("rst_ctrl", 32'(q), 32'h00);
    peek(A_DATA, q, oe); chk("rst_rx", 32'(q), 32'h00);

    // basic transfer
    acc(A_CTRL, 8'h08, 1'b0, 1'b0, q, oe);
    chk("cs_on", 32'(cs_n), 32'd0);
    sval = 8'h3C; f0 = falls; r0 = rises; h0 = hi_cnt;
    acc(A_DATA, 8'hA5, 1'b0, 1'b0, q, oe);
    wait_idle(n);
    chk("busy_len", 32'(n), 32'd32);
    chk("sclk_pulses", 32'(rises - r0), 32'd8);
    chk("sclk_hi_cyc", 32'(hi_cnt - h0), 32'd16);
    chk("sdo_seq", 32'(sdo_cap), 32'hA5);
    chk("cs_during", 32'(cs_n), 32'd0);
    peek(A_CTRL, q, oe); chk("ctrl_done", 32'(q), 32'h0A);
    acc(A_DATA, 8'h00, 1'b1, 1'b0, q, oe); chk("rx_basic", 32'(q), 32'h3C);
    peek(A_CTRL, q, oe); chk("ctrl_clr", 32'(q), 32'h08);

    // overrun
    sval = 8'h96; f0 = falls;
    acc(A_DATA, 8'h11, 1'b0, 1'b0, q, oe);
    repeat (3) @(negedge clk);
    acc(A_DATA, 8'h22, 1'b0, 1'b0, q, oe);
    wait_idle(n);
    chk("ovr_sdo", 32'(sdo_cap), 32'h11);
    peek(A_CTRL, q, oe); chk("ovr_ctrl", 32'(q), 32'h0E);
    acc(A_CTRL, 8'h0C, 1'b0, 1'b0, q, oe);
    peek(A_CTRL, q, oe); chk("ovr_w1c", 32'(q), 32'h0A);
    acc(A_DATA, 8'h00, 1'b1, 1'b0, q, oe); chk("rx_ovr", 32'(q), 32'h96);

    // decode misses: off-window register, wrong base, deselected
    acc(14'h1002, 8'hFF, 1'b1, 1'b0, q, oe); chk("dec_1002_oe", 32'(oe), 32'd0);
    chk("dec_1002_q", 32'(q), 32'd0);
    acc(14'h1002, 8'hFF, 1'b0, 1'b0, q, oe);
    acc(14'h0000, 8'hFF, 1'b1, 1'b0, q, oe); chk("dec_0000_oe", 32'(oe), 32'd0);
    acc(14'h0000, 8'hFF, 1'b0, 1'b0, q, oe);
    acc(14'h0001, 8'hFF, 1'b0, 1'b0, q, oe);
    acc(A_DATA, 8'hFF, 1'b1, 1'b1, q, oe); chk("dec_sel_oe", 32'(oe), 32'd0);
    acc(A_DATA, 8'hFF, 1'b0, 1'b1, q, oe);
    acc(A_CTRL, 8'h04, 1'b0, 1'b1, q, oe);
    repeat (3) @(negedge clk);
    peek(A_CTRL, q, oe); chk("dec_ctrl", 32'(q), 32'h08);
    peek(A_DATA, q, oe); chk("dec_rx", 32'(q), 32'h96);
    chk("dec_sclk", 32'(sclk), 32'd0);

    // completion edge + DATA read strobe: done stays set
    sval = 8'hC3; f0 = falls;
    acc(A_DATA, 8'h5A, 1'b0, 1'b0, q, oe);
    repeat (30) @(negedge clk);
    acc(A_DATA, 8'h00, 1'b1, 1'b0, q, oe);
    peek(A_CTRL, q, oe); chk("col_rd_ctrl", 32'(q), 32'h0A);
    acc(A_DATA, 8'h00, 1'b1, 1'b0, q, oe); chk("col_rx", 32'(q), 32'hC3);

    // completion edge + DATA write: counts as busy
    f0 = falls;
    acc(A_DATA, 8'h81, 1'b0, 1'b0, q, oe);
    repeat (30) @(negedge clk);
    acc(A_DATA, 8'h77, 1'b0, 1'b0, q, oe);
    repeat (4) @(negedge clk);
    peek(A_CTRL, q, oe); chk("col_wr_ctrl", 32'(q), 32'h0E);
    chk("col_wr_sdo", 32'(sdo), 32'd1);
    chk("col_wr_sclk", 32'(sclk), 32'd0);
    acc(A_CTRL, 8'h0C, 1'b0, 1'b0, q, oe);
    acc(A_DATA, 8'h00, 1'b1, 1'b0, q, oe);
    peek(A_CTRL, q, oe); chk("col_clean", 32'(q), 32'h08);

    // cs is locked while busy
    f0 = falls;
    acc(A_DATA, 8'h00, 1'b0, 1'b0, q, oe);
    acc(A_CTRL, 8'h00, 1'b0, 1'b0, q, oe);
    chk("lock_cs_n", 32'(cs_n), 32'd0);
    peek(A_CTRL, q, oe); chk("lock_ctrl", 32'(q), 32'h09);
    wait_idle(n);
    chk("lock_after", 32'(cs_n), 32'd0);
    acc(A_CTRL, 8'h00, 1'b0, 1'b0, q, oe);
    chk("unlock_cs_n", 32'(cs_n), 32'd1);
    peek(A_CTRL, q, oe); chk("unlock_ctrl", 32'(q), 32'h02);

    // reset mid-transfer
    acc(A_CTRL, 8'h08, 1'b0, 1'b0, q, oe);
    f0 = falls;
    acc(A_DATA, 8'hFF, 1'b0, 1'b0, q, oe);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mrst_sclk", 32'(sclk), 32'd0);
    chk("mrst_cs_n", 32'(cs_n), 32'd1);
    peek(A_CTRL, q, oe); chk("mrst_ctrl", 32'(q), 32'h00);
    r0 = rises;
    repeat (20) @(negedge clk);
    chk("mrst_no_sclk", 32'(rises - r0), 32'd0);
    peek(A_DATA, q, oe); chk("mrst_rx", 32'(q), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
